// File: rtl/csr_fifo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : csr_fifo_bridge
// Brief    : APB register block with TX/RX FIFOs and a maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module csr_fifo_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int FIFO_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tx_valid,
    output logic [FIFO_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [FIFO_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_DATA    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] c_ADDR_LEVEL   = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL    = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] c_ADDR_THRESH  = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] c_ADDR_INTSTAT = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] c_ADDR_INTEN   = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] c_ADDR_PARAM   = ADDR_W'(8'h18);

    logic [FIFO_W-1:0] r_tx_mem [DEPTH];
    logic [FIFO_W-1:0] r_rx_mem [DEPTH];
    logic [PTR_W-1:0]  r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
    logic [CNT_W-1:0]  r_tx_level, r_rx_level;
    logic              r_txen, r_rxen;
    logic [15:0]       r_tx_thr, r_rx_thr;
    logic [4:0]        r_intstat, r_inten;
    logic              r_irq;
    logic              r_rd_phase, r_rd_pop, r_rd_unf;
    logic [DATA_W-1:0] r_prdata;

    logic w_hit_data, w_hit_level, w_hit_ctrl, w_hit_thresh;
    logic w_hit_intstat, w_hit_inten, w_hit_param, w_mapped;
    logic w_wr, w_rd_first;
    logic w_tx_full, w_tx_empty, w_tx_req, w_tx_push, w_tx_pop, w_tx_clr, w_tx_ovf;
    logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_clr, w_rx_ovf, w_rx_unf;
    logic w_tx_low, w_rx_high;
    logic [15:0]       w_tx_lvl16, w_rx_lvl16;
    logic [4:0]        w_w1c, w_int_set;
    logic [DATA_W-1:0] w_rd_data;

    assign w_hit_data    = (paddr == c_ADDR_DATA);
    assign w_hit_level   = (paddr == c_ADDR_LEVEL);
    assign w_hit_ctrl    = (paddr == c_ADDR_CTRL);
    assign w_hit_thresh  = (paddr == c_ADDR_THRESH);
    assign w_hit_intstat = (paddr == c_ADDR_INTSTAT);
    assign w_hit_inten   = (paddr == c_ADDR_INTEN);
    assign w_hit_param   = (paddr == c_ADDR_PARAM);
    assign w_mapped      = w_hit_data | w_hit_level | w_hit_ctrl | w_hit_thresh |
                           w_hit_intstat | w_hit_inten | w_hit_param;

    // Reads take two access cycles: the first registers prdata, the second completes.
    assign w_wr       = psel & penable & pwrite & !rst;
    assign w_rd_first = psel & penable & !pwrite & !r_rd_phase & !rst;
    assign pready     = !w_rd_first;
    assign pslverr    = psel & penable & pready & !w_mapped & !rst;
    assign prdata     = r_rd_phase ? r_prdata : '0;

    assign w_tx_full  = (r_tx_level == CNT_W'(DEPTH));
    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_clr   = w_wr & w_hit_ctrl & pstrb[0] & pwdata[2];
    assign w_tx_req   = w_wr & w_hit_data & pstrb[0];
    assign w_tx_push  = w_tx_req & !w_tx_full & !w_tx_clr;
    assign w_tx_ovf   = w_tx_req & w_tx_full & !w_tx_clr;
    assign tx_valid   = r_txen & !w_tx_empty;
    assign tx_data    = w_tx_empty ? '0 : r_tx_mem[r_tx_rd_ptr];
    assign w_tx_pop   = tx_valid & tx_ready & !w_tx_clr;

    assign w_rx_full  = (r_rx_level == CNT_W'(DEPTH));
    assign w_rx_empty = (r_rx_level == '0);
    assign w_rx_clr   = w_wr & w_hit_ctrl & pstrb[0] & pwdata[3];
    assign rx_ready   = r_rxen & !w_rx_full;
    assign w_rx_push  = rx_valid & rx_ready & !w_rx_clr & !rst;
    assign w_rx_ovf   = r_rxen & rx_valid & w_rx_full & !w_rx_clr;
    assign w_rx_pop   = r_rd_phase & r_rd_pop & !w_rx_clr;
    assign w_rx_unf   = r_rd_phase & r_rd_unf;

    assign w_tx_lvl16 = 16'(r_tx_level);
    assign w_rx_lvl16 = 16'(r_rx_level);
    assign w_tx_low   = (w_tx_lvl16 <= r_tx_thr);
    assign w_rx_high  = (r_rx_thr != 16'd0) && (w_rx_lvl16 >= r_rx_thr);
    assign w_int_set  = {w_rx_unf, w_rx_ovf, w_tx_ovf, w_rx_high, w_tx_low};
    assign w_w1c      = (w_wr & w_hit_intstat & pstrb[0]) ? pwdata[4:0] : 5'd0;
    assign irq        = r_irq;

    always_comb begin
        w_rd_data = '0;
        if (w_hit_data) begin
            w_rd_data = w_rx_empty ? 32'h8000_0000 : DATA_W'(r_rx_mem[r_rx_rd_ptr]);
        end else if (w_hit_level) begin
            w_rd_data = {w_rx_lvl16, w_tx_lvl16};
        end else if (w_hit_ctrl) begin
            w_rd_data = DATA_W'({r_rxen, r_txen});
        end else if (w_hit_thresh) begin
            w_rd_data = {r_rx_thr, r_tx_thr};
        end else if (w_hit_intstat) begin
            w_rd_data = DATA_W'(r_intstat);
        end else if (w_hit_inten) begin
            w_rd_data = DATA_W'(r_inten);
        end else if (w_hit_param) begin
            w_rd_data = {8'd0, 8'(FIFO_W), 16'(DEPTH)};
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= pwdata[FIFO_W-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= rx_data;
    end

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || w_tx_clr) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_level  <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_rx_clr) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_level  <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_level <= r_rx_level + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_level <= r_rx_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txen     <= 1'b0;
            r_rxen     <= 1'b0;
            r_tx_thr   <= '0;
            r_rx_thr   <= '0;
            r_intstat  <= '0;
            r_inten    <= '0;
            r_irq      <= 1'b0;
            r_rd_phase <= 1'b0;
            r_rd_pop   <= 1'b0;
            r_rd_unf   <= 1'b0;
            r_prdata   <= '0;
        end else begin
            if (w_wr && w_hit_ctrl && pstrb[0]) begin
                r_txen <= pwdata[0];
                r_rxen <= pwdata[1];
            end
            if (w_wr && w_hit_thresh) begin
                if (pstrb[0]) r_tx_thr[7:0]  <= pwdata[7:0];
                if (pstrb[1]) r_tx_thr[15:8] <= pwdata[15:8];
                if (pstrb[2]) r_rx_thr[7:0]  <= pwdata[23:16];
                if (pstrb[3]) r_rx_thr[15:8] <= pwdata[31:24];
            end
            if (w_wr && w_hit_inten && pstrb[0]) r_inten <= pwdata[4:0];
            r_intstat  <= (r_intstat & ~w_w1c) | w_int_set;
            r_irq      <= |(r_intstat & r_inten);
            r_rd_phase <= w_rd_first;
            r_rd_pop   <= w_rd_first & w_hit_data & !w_rx_empty;
            r_rd_unf   <= w_rd_first & w_hit_data & w_rx_empty;
            if (w_rd_first) r_prdata <= w_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_fifo_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_csr_fifo_bridge
// Brief    : Scoreboard bench for csr_fifo_bridge (APB reads and TX pops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_fifo_bridge;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int FIFO_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    localparam logic [15:0] c_DATA    = 16'h00;
    localparam logic [15:0] c_LEVEL   = 16'h04;
    localparam logic [15:0] c_CTRL    = 16'h08;
    localparam logic [15:0] c_THRESH  = 16'h0C;
    localparam logic [15:0] c_INTSTAT = 16'h10;
    localparam logic [15:0] c_INTEN   = 16'h14;
    localparam logic [15:0] c_PARAM   = 16'h18;
    localparam logic [15:0] c_UNMAP   = 16'h1C;

    logic              clk, rst;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr;
    logic              tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [FIFO_W-1:0] tx_data, rx_data;

    csr_fifo_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
        .FIFO_W(FIFO_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [32:0] exp_rd_q [$];
    string       exp_nm_q [$];
    logic [7:0]  exp_tx_q [$];
    int          tx_idx = 0;
    logic [32:0] mon_rd;
    string       mon_nm;
    logic [7:0]  mon_tx;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    endtask

    // Monitor: APB read completions and TX handshakes are checked against queued expectations.
    always @(negedge clk) begin
        if (!rst && psel && penable && !pwrite && pready) begin
            if (exp_rd_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", prdata);
            end else begin
                mon_rd = exp_rd_q.pop_front();
                mon_nm = exp_nm_q.pop_front();
                check(mon_nm, {pslverr, prdata}, mon_rd);
            end
        end
        if (!rst && tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_unexpected: got 0x%02h expected no pop", tx_data);
            end else begin
                mon_tx = exp_tx_q.pop_front();
                check($sformatf("tx_pop%0d", tx_idx), 33'(tx_data), 33'(mon_tx));
                tx_idx++;
            end
        end
    end

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit pop, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        if (pop) tx_ready = 1'b1;
        @(negedge clk);
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (pop) tx_ready = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, 4'hF, 1'b0, e);
    endtask

    task automatic apb_read(input logic [15:0] a, input logic [31:0] exp, input logic exp_err,
                            input string name);
        int  waits;
        bit  done;
        exp_rd_q.push_back({exp_err, exp});
        exp_nm_q.push_back(name);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
            else waits++;
        end
        check({name, "_waits"}, 33'(waits), 33'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] w);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = w;
    endtask

    task automatic rx_idle();
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_outs"}, 33'({tx_valid, tx_data, rx_ready, irq, pready, pslverr}),
              33'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
        check({tag, "_prdata"}, 33'(prdata), 33'd0);
    endtask

    initial begin
        logic e;
        bit   drained;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        apb_read(c_PARAM,   32'h0008_0010, 1'b0, "param");
        apb_read(c_LEVEL,   32'h0000_0000, 1'b0, "level0");
        apb_read(c_CTRL,    32'h0000_0000, 1'b0, "ctrl0");
        apb_read(c_INTSTAT, 32'h0000_0001, 1'b0, "intstat_txlow");

        // Fill TX past full; the 17th word is dropped as an overflow.
        wr(c_CTRL, 32'h1);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_tx_q.push_back(8'hA0 + 8'(i));
            wr(c_DATA, 32'(8'hA0 + 8'(i)));
        end
        check("tx_valid_full", 33'(tx_valid), 33'd1);
        apb_read(c_LEVEL,   32'h0000_0010, 1'b0, "level_txfull");
        apb_read(c_INTSTAT, 32'h0000_0005, 1'b0, "intstat_txovf");

        @(posedge clk); #1;
        tx_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 40 && !drained; i++) begin
            @(negedge clk);
            if (!tx_valid) drained = 1'b1;
        end
        check("tx_drained", 33'(drained), 33'd1);
        check("tx_exp_left", 33'(exp_tx_q.size()), 33'd0);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        wr(c_INTSTAT, 32'h1F);

        // RX path and underflow.
        wr(c_CTRL, 32'h2);
        rx_send(8'h11);
        rx_send(8'h22);
        rx_idle();
        apb_read(c_DATA,    32'h0000_0011, 1'b0, "rx_pop0");
        apb_read(c_DATA,    32'h0000_0022, 1'b0, "rx_pop1");
        apb_read(c_DATA,    32'h8000_0000, 1'b0, "rx_unf");
        apb_read(c_INTSTAT, 32'h0000_0011, 1'b0, "intstat_rxunf");
        wr(c_INTSTAT, 32'h1F);

        // RX threshold interrupt.
        begin
            logic e2;
            apb_write(c_THRESH, 32'h0004_0000, 4'b1100, 1'b0, e2);
        end
        wr(c_INTEN, 32'h2);
        rx_send(8'h31);
        rx_send(8'h32);
        rx_send(8'h33);
        rx_send(8'h34);
        rx_idle();
        @(negedge clk);
        check("irq_pre0", 33'(irq), 33'd0);
        @(negedge clk);
        check("irq_pre1", 33'(irq), 33'd0);
        @(negedge clk);
        check("irq_rise", 33'(irq), 33'd1);
        wr(c_INTSTAT, 32'h2);
        check("irq_hold", 33'(irq), 33'd1);
        apb_read(c_INTSTAT, 32'h0000_0003, 1'b0, "intstat_reset_rxhigh");
        apb_read(c_DATA,    32'h0000_0031, 1'b0, "rx_pop_thr");
        wr(c_INTSTAT, 32'h2);
        repeat (2) @(negedge clk);
        check("irq_clear", 33'(irq), 33'd0);
        apb_read(c_INTSTAT, 32'h0000_0001, 1'b0, "intstat_after_clr");

        // TX flush colliding with a core pop.
        wr(c_CTRL, 32'h1);
        wr(c_DATA, 32'h51);
        wr(c_DATA, 32'h52);
        wr(c_DATA, 32'h53);
        exp_tx_q.push_back(8'h51);
        apb_write(c_CTRL, 32'h5, 4'hF, 1'b1, e);
        @(negedge clk);
        check("tx_valid_flushed", 33'(tx_valid), 33'd0);
        apb_read(c_LEVEL,   32'h0003_0000, 1'b0, "level_flushed");
        apb_read(c_CTRL,    32'h0000_0001, 1'b0, "ctrl_selfclr");
        apb_read(c_INTSTAT, 32'h0000_0001, 1'b0, "intstat_noovf");

        // Error responses.
        apb_read(c_UNMAP, 32'h0000_0000, 1'b1, "unmapped_rd");
        apb_write(c_UNMAP, 32'hFFFF_FFFF, 4'hF, 1'b0, e);
        check("unmapped_wr_err", 33'(e), 33'd1);
        apb_write(c_LEVEL, 32'hFFFF_FFFF, 4'hF, 1'b0, e);
        check("ro_wr_err", 33'(e), 33'd0);
        apb_read(c_LEVEL, 32'h0003_0000, 1'b0, "level_ro");

        // Reset during the first access cycle of a DATA read.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = c_DATA;
        @(posedge clk); #1;
        penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        apb_read(c_LEVEL,   32'h0000_0000, 1'b0, "level_after_rst");
        apb_read(c_CTRL,    32'h0000_0000, 1'b0, "ctrl_after_rst");

        repeat (2) @(negedge clk);
        check("rd_exp_left", 33'(exp_rd_q.size()), 33'd0);
        check("tx_exp_left_end", 33'(exp_tx_q.size()), 33'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
